pipe_hazard_ctrl: RTL and testbench

//  Parametrised in-order pipeline hazard/issue controller; successor to the fixed 5-stage hazard_detection/forwarding pair.

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : in-order issue/hazard controller beside ID. It tracks every instruction past ID,
//           makes the issue/stall/flush decision, selects operand forwarding and handles the HLT drain.
// Latency : all decisions are combinational in the same cycle. Stage state updates at the next clk edge.
// Backpressure: stall freezes PC and IF/ID on a RAW hazard that cannot be forwarded, and after an HLT has issued.
// Ports   : clk/rst_n (async active-low reset).
//           Inputs: id_* describe the ID instruction; branch_taken is the taken-branch resolution from ID.
//           Outputs: issue, stall and flush_ifid are the ID control. fwd_a_sel/fwd_b_sel select the
//           operand mux (0 = regfile, k+1 = stage k). stage_valid gives per-stage occupancy.
//           halted is sticky once the pipeline has drained after HLT.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 4,
  parameter int ALU_RDY    = 1,
  parameter int LOAD_RDY   = 2,
  parameter int FWD_EN     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            id_valid,
  input  logic [REG_AW-1:0]               id_rs,
  input  logic                            id_rs_used,
  input  logic [REG_AW-1:0]               id_rt,
  input  logic                            id_rt_used,
  input  logic                            id_wr_en,
  input  logic [REG_AW-1:0]               id_rd,
  input  logic                            id_is_load,
  input  logic                            id_halt,
  input  logic                            branch_taken,
  output logic                            issue,
  output logic                            stall,
  output logic                            flush_ifid,
  output logic [$clog2(NUM_STAGES+1)-1:0] fwd_a_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0] fwd_b_sel,
  output logic [NUM_STAGES-1:0]           stage_valid,
  output logic                            halted
);

  localparam int SW = $clog2(NUM_STAGES+1);

  // Per-stage entry {valid, wr_en, rd, is_load}; index 0 is the youngest (EX).
  logic [NUM_STAGES-1:0] vld_q, vld_d;
  logic [NUM_STAGES-1:0] wr_q, wr_d;
  logic [NUM_STAGES-1:0] ld_q, ld_d;
  logic [REG_AW-1:0]     rd_q [NUM_STAGES];
  logic [REG_AW-1:0]     rd_d [NUM_STAGES];

  logic halt_pending_q, halt_pending_d;
  logic halted_q, halted_d;

  logic          raw_a, raw_b;
  logic [SW-1:0] sel_a, sel_b;

  // Returns {raw_stall, sel} for one source operand.
  function automatic logic [SW:0] resolve(
    input logic [REG_AW-1:0]     src,
    input logic                  used,
    input logic [NUM_STAGES-1:0] vld,
    input logic [NUM_STAGES-1:0] wr,
    input logic [NUM_STAGES-1:0] ld,
    input logic [REG_AW-1:0]     rd [NUM_STAGES]
  );
    logic          stl;
    logic [SW-1:0] sel;
    stl = 1'b0;
    sel = '0;
    if (used && (src != '0)) begin
      // Walk oldest to youngest so that a younger writer overrides an older one.
      for (int k = NUM_STAGES-1; k >= 0; k--) begin
        if (vld[k] && wr[k] && (rd[k] == src)) begin
          if (k == NUM_STAGES-1) begin
            // The last stage is writing the regfile this cycle. Without forwarding,
            // the regfile's write-before-read bypass supplies the value.
            stl = 1'b0;
            sel = (FWD_EN != 0) ? SW'(k+1) : '0;
          end else if ((FWD_EN != 0) && (k >= (ld[k] ? LOAD_RDY : ALU_RDY))) begin
            stl = 1'b0;
            sel = SW'(k+1);
          end else begin
            stl = 1'b1;
            sel = '0;
          end
        end
      end
    end
    return {stl, sel};
  endfunction

  always_comb begin
    {raw_a, sel_a} = resolve(id_rs, id_rs_used, vld_q, wr_q, ld_q, rd_q);
    {raw_b, sel_b} = resolve(id_rt, id_rt_used, vld_q, wr_q, ld_q, rd_q);

    stall      = id_valid & (raw_a | raw_b | halt_pending_q);
    issue      = id_valid & ~stall & ~halt_pending_q;
    flush_ifid = branch_taken & issue;
    fwd_a_sel  = id_valid ? sel_a : '0;
    fwd_b_sel  = id_valid ? sel_b : '0;
  end

  // Shift the tracker by one stage; stage 0 takes the issuing instruction or a bubble.
  always_comb begin
    vld_d    = {vld_q[NUM_STAGES-2:0], issue};
    wr_d     = {wr_q[NUM_STAGES-2:0], issue & id_wr_en};
    ld_d     = {ld_q[NUM_STAGES-2:0], issue & id_is_load};
    rd_d[0]  = issue ? id_rd : '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      rd_d[k] = rd_q[k-1];
    end
    halt_pending_d = halt_pending_q | (issue & id_halt);
    // halted rises on the same edge that empties the last stage.
    halted_d       = halted_q | (halt_pending_q & ~(|vld_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q          <= '0;
      wr_q           <= '0;
      ld_q           <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        rd_q[k] <= '0;
      end
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      vld_q          <= vld_d;
      wr_q           <= wr_d;
      ld_q           <= ld_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        rd_q[k] <= rd_d[k];
      end
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
    end
  end

  assign stage_valid = vld_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_valid_nf;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used, id_wr_en, id_is_load, id_halt, branch_taken;

  logic       issue, stall, flush_ifid, halted;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [2:0] stage_valid;

  logic       issue_nf, stall_nf, flush_nf, halted_nf;
  logic [1:0] fwd_a_nf, fwd_b_nf;
  logic [2:0] sv_nf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .id_halt(id_halt),
    .branch_taken(branch_taken), .issue(issue), .stall(stall), .flush_ifid(flush_ifid),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stage_valid(stage_valid), .halted(halted)
  );

  pipe_hazard_ctrl #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid_nf),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .id_halt(id_halt),
    .branch_taken(branch_taken), .issue(issue_nf), .stall(stall_nf), .flush_ifid(flush_nf),
    .fwd_a_sel(fwd_a_nf), .fwd_b_sel(fwd_b_nf), .stage_valid(sv_nf), .halted(halted_nf)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // v drives the forwarding instance, v2 the FWD_EN=0 instance; other fields are shared.
  task automatic drv(input logic v, input logic v2,
                     input logic [3:0] rs, input logic rsu,
                     input logic [3:0] rt, input logic rtu,
                     input logic we, input logic [3:0] rd, input logic ld,
                     input logic hlt, input logic br);
    id_valid = v;    id_valid_nf = v2;
    id_rs = rs;      id_rs_used = rsu;
    id_rt = rt;      id_rt_used = rtu;
    id_wr_en = we;   id_rd = rd;   id_is_load = ld;
    id_halt = hlt;   branch_taken = br;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    check("rst_stage_valid", stage_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_issue", issue, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush_ifid, 0);
    check("rst_fwd_a", fwd_a_sel, 0);
    check("rst_fwd_b", fwd_b_sel, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ADD r3 then SUB rs=r3: one stall, then forward from stage 1
    drv(1, 0, 4'd1, 1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    check("add_issue", issue, 1);
    tick();
    check("add_sv", stage_valid, 1);
    drv(1, 0, 4'd3, 1, 4'd1, 1, 1, 4'd6, 0, 0, 0);
    check("alu_use_stall", stall, 1);
    check("alu_use_noissue", issue, 0);
    tick();
    check("alu_use_issue", issue, 1);
    check("alu_use_stall_off", stall, 0);
    check("alu_use_fwd_a", fwd_a_sel, 2);
    check("alu_use_fwd_b", fwd_b_sel, 0);
    tick();
    drain();
    check("drain_sv", stage_valid, 0);

    // LW r5 then ADD rt=r5: two stalls, then forward from stage 2
    drv(1, 0, 4'd1, 1, 4'd0, 0, 1, 4'd5, 1, 0, 0);
    check("lw_issue", issue, 1);
    tick();
    drv(1, 0, 4'd2, 1, 4'd5, 1, 1, 4'd7, 0, 0, 0);
    check("lu_stall1", stall, 1);
    check("lu_noissue1", issue, 0);
    tick();
    check("lu_stall2", stall, 1);
    check("lu_noissue2", issue, 0);
    tick();
    check("lu_issue", issue, 1);
    check("lu_fwd_b", fwd_b_sel, 3);
    check("lu_fwd_a", fwd_a_sel, 0);
    tick();
    drain();

    // Write r0 then read r0: no hazard
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0);
    tick();
    drv(1, 0, 4'd0, 1, 4'd0, 0, 1, 4'd2, 0, 0, 0);
    check("r0_stall", stall, 0);
    check("r0_issue", issue, 1);
    check("r0_fwd_a", fwd_a_sel, 0);
    tick();
    drain();

    // Two writers of r4 in stages 1 and 2: the younger one wins
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd4, 0, 0, 0);
    tick();
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd4, 0, 0, 0);
    tick();
    idle();
    tick();
    drv(1, 0, 4'd4, 1, 4'd4, 1, 1, 4'd9, 0, 0, 0);
    check("shadow_sv", stage_valid, 6);
    check("shadow_issue", issue, 1);
    check("shadow_fwd_a", fwd_a_sel, 2);
    check("shadow_fwd_b", fwd_b_sel, 2);
    tick();
    drain();

    // Taken branch without hazard flushes IF/ID
    drv(1, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1);
    check("br_issue", issue, 1);
    check("br_flush", flush_ifid, 1);
    tick();
    drain();

    // Taken branch stuck behind a load-use stall
    drv(1, 0, 4'd1, 1, 4'd0, 0, 1, 4'd8, 1, 0, 0);
    tick();
    drv(1, 0, 4'd8, 1, 4'd0, 0, 0, 4'd0, 0, 0, 1);
    check("brst_stall1", stall, 1);
    check("brst_noflush1", flush_ifid, 0);
    tick();
    check("brst_stall2", stall, 1);
    check("brst_noflush2", flush_ifid, 0);
    tick();
    check("brst_issue", issue, 1);
    check("brst_flush", flush_ifid, 1);
    check("brst_fwd_a", fwd_a_sel, 3);
    tick();
    drain();

    // Forwarding disabled: ADD r3 then use of r3 stalls twice, then reads the regfile
    drv(0, 1, 4'd1, 1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    check("nf_add_issue", issue_nf, 1);
    tick();
    drv(0, 1, 4'd3, 1, 4'd1, 1, 1, 4'd6, 0, 0, 0);
    check("nf_stall1", stall_nf, 1);
    check("nf_noissue1", issue_nf, 0);
    tick();
    check("nf_stall2", stall_nf, 1);
    check("nf_noissue2", issue_nf, 0);
    tick();
    check("nf_issue", issue_nf, 1);
    check("nf_stall_off", stall_nf, 0);
    check("nf_fwd_a", fwd_a_nf, 0);
    check("nf_fwd_b", fwd_b_nf, 0);
    tick();
    drain();
    check("nf_main_idle_sv", stage_valid, 0);

    // HLT with two older instructions in flight
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd1, 0, 0, 0);
    tick();
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd2, 0, 0, 0);
    tick();
    drv(1, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0);
    check("hlt_issue", issue, 1);
    tick();
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd5, 0, 0, 0);
    check("hlt_sv0", stage_valid, 7);
    check("hlt_halted0", halted, 0);
    check("hlt_stall", stall, 1);
    check("hlt_noissue", issue, 0);
    tick();
    check("hlt_sv1", stage_valid, 6);
    check("hlt_halted1", halted, 0);
    tick();
    check("hlt_sv2", stage_valid, 4);
    check("hlt_halted2", halted, 0);
    tick();
    check("hlt_sv3", stage_valid, 0);
    check("hlt_halted3", halted, 1);
    check("hlt_stall_hold", stall, 1);
    idle();
    check("hlt_idle_stall", stall, 0);
    tick();
    check("hlt_sticky", halted, 1);

    // Async reset clears halted, then clears in-flight entries mid-run
    rst_n = 1'b0;
    #1;
    check("arst_halted", halted, 0);
    rst_n = 1'b1;
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd1, 0, 0, 0);
    check("post_rst_issue", issue, 1);
    tick();
    drv(1, 0, 4'd0, 0, 4'd0, 0, 1, 4'd2, 0, 0, 0);
    tick();
    check("pre_arst_sv", stage_valid, 3);
    rst_n = 1'b0;
    #1;
    check("arst_sv", stage_valid, 0);
    check("arst_halted2", halted, 0);
    rst_n = 1'b1;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
